tile_render_ctrl: RTL and testbench
===================================

// Module: tile_render_ctrl
// PURPOSE
//  Per-pixel scheduler for the minesweeper tile datapath. Maps each (h_coord, v_coord) to a field cell,
//  fetches that cell's state/visibility from the cell store, and selects the sprite and in-tile ROM address.
//  Overlays a blinking player cursor, then registers final RGB. Sits between SVGA timing, game_fsm cell
//  store and the shared tile-ROM bank.
// PARAMETERS
//  FIELD_TOP     88   first field scanline; field = 25 cols x 16 rows of 32x32 tiles below it
//  FIELD_COLS    25   columns (800/32)
//  FIELD_ROWS    16   rows ((600-88)/32)
//  BLINK_FRAMES  16   frames per cursor blink half-period (>=1)
//  CURSOR_RGB    12'hF00  cursor colour {b,g,r}
// PORTS
//  pixel_clk       in   1   pixel clock 36 MHz
//  rst_n           in   1   reset, synchronous, active-low
//  h_coord         in   11  current pixel column
//  v_coord         in   10  current pixel row
//  sw_bg           in   3   background enables {b,g,r}, each -> 4'h8
//  player_x        in   5   cursor cell column
//  player_y        in   4   cursor cell row
//  cursor_blink_en in   1   1: cursor blinks, 0: cursor steady on
//  cell_rd_en      out  1   cell-store read strobe
//  cell_rd_addr    out  9   {row[3:0], col[4:0]}
//  cell_state_i    in   4   0 empty, 1..8 count, 9 mine, 10 exploded; valid 1 cycle after rd_en
//  cell_vis_i      in   2   0 hidden, 1 flagged, 2 revealed, 3 reserved (=hidden)
//  sprite_sel      out  4   tile-ROM bank select 0..12
//  rom_addr        out  10  {ty[4:0], tx[4:0]} in-tile address
//  rom_data_i      in   12  selected sprite word {b,g,r}, combinational from sprite_sel/rom_addr
//  red/green/blue  out  4 each  registered pixel colour
//  pix_valid       out  1   rgb corresponds to an active pixel (h<800, v<600)
//  frame_pulse     out  1   1-cycle pulse after pixel (799,599) enters S0
// BEHAVIOUR
//  Reset: all outputs 0; pipeline valid bits, blink counter and blink_phase cleared. Reset mid-frame
//  flushes the pipeline; first valid pixel appears 3 cycles after the first post-reset active coordinate.
//  Pipeline (fixed latency 3, no stalls):
//   S1: act = h<800 && v<600; fld = act && v>=FIELD_TOP; col = h[9:5]; vrel = v-FIELD_TOP;
//       row = vrel[8:5]; tx = h[4:0]; ty = vrel[4:0]; cell_rd_en = fld; cell_rd_addr = {row, col}.
//       col>=FIELD_COLS or row>=FIELD_ROWS -> fld = 0, no read.
//   S2: sprite_sel/rom_addr registered from S1 + cell data:
//       vis 0/3 -> 0 tile; vis 1 -> 1 flag; vis 2: state 0 -> 12, 1..8 -> state+1, 9 -> 10, 10 -> 11,
//       11..15 -> 0. Cursor hit = (col==player_x && row==player_y) && (tx or ty in {0,1,30,31}).
//   S3: rgb = !act ? 0 : !fld ? sw_bg colour : (hit && show) ? CURSOR_RGB : rom_data_i.
//       pix_valid = act delayed 3.
//  Unused cell_state/cell_vis while cell_rd_en = 0 are ignored.
//  Blink: on frame_pulse, cnt == BLINK_FRAMES-1 -> cnt = 0, blink_phase toggles; else cnt++.
//  show = !cursor_blink_en || !blink_phase. Cursor has no effect when player_x>=COLS or player_y>=ROWS.
//  Width rules: vrel computed in 10 bits, only used when v>=FIELD_TOP (no wrap). h[10] set -> inactive.
//  frame_pulse asserts once per frame even if coords repeat (799,599) for 1 cycle only. With
//  BLINK_FRAMES=1, the phase toggles every frame.
// TESTING
//  1. Reset, drive h=0, v=88, revealed state 3 -> cycle1 rd_addr=0x000; cycle2 sprite_sel=4, rom_addr=0;
//     cycle3 rgb=rom_data_i.
//  2. h=37, v=130 (col1,row1,tx5,ty10), vis=1 -> rd_addr=0x021, sprite_sel=1, rom_addr=0x145.
//  3. v=50, sw_bg=3'b101 -> cell_rd_en=0, rgb={b8,g0,r8}, pix_valid=1. h=810 -> rgb=0, pix_valid=0.
//  4. player=(2,3), blink_en=0, h=64, v=184 (tx0) -> rgb=CURSOR_RGB; h=74 (tx10, ty0) -> cursor;
//     h=74, v=194 -> ROM word.
//  5. blink_en=1, BLINK_FRAMES=2 -> cursor visible frames 0-1, hidden 2-3, visible 4-5;
//     frame_pulse once per frame.
//  6. Assert rst_n=0 mid-line for 1 cycle -> all outputs 0 the next cycle; pix_valid returns 3 cycles
//     after release; cnt restarts at 0.

Source files
------------

// File: rtl/tile_render_ctrl.sv
// Per-pixel tile scheduler: maps screen coordinates to field cells, picks the sprite and
// in-tile ROM address, overlays the blinking cursor and registers the final colour (latency 3).
module tile_render_ctrl #(
    parameter int          FIELD_TOP    = 88,
    parameter int          FIELD_COLS   = 25,
    parameter int          FIELD_ROWS   = 16,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [11:0] CURSOR_RGB   = 12'hF00
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] h_coord,
    input  logic [9:0]  v_coord,
    input  logic [2:0]  sw_bg,
    input  logic [4:0]  player_x,
    input  logic [3:0]  player_y,
    input  logic        cursor_blink_en,
    output logic        cell_rd_en,
    output logic [8:0]  cell_rd_addr,
    input  logic [3:0]  cell_state_i,
    input  logic [1:0]  cell_vis_i,
    output logic [3:0]  sprite_sel,
    output logic [9:0]  rom_addr,
    input  logic [11:0] rom_data_i,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        pix_valid,
    output logic        frame_pulse
);

    localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]      TOP_V    = 10'(FIELD_TOP);
    localparam logic [5:0]      COLS_L   = 6'(FIELD_COLS);
    localparam logic [4:0]      ROWS_L   = 5'(FIELD_ROWS);

    function automatic logic [3:0] sprite_of(input logic [3:0] state, input logic [1:0] vis);
        logic [3:0] s;
        s = 4'd0;
        if (vis == 2'd1) begin
            s = 4'd1;
        end else if (vis == 2'd2) begin
            if (state == 4'd0)       s = 4'd12;
            else if (state <= 4'd8)  s = state + 4'd1;
            else if (state == 4'd9)  s = 4'd10;
            else if (state == 4'd10) s = 4'd11;
        end
        return s;
    endfunction

    function automatic logic on_border(input logic [4:0] t);
        return (t[4:1] == 4'h0) || (t[4:1] == 4'hF);
    endfunction

    function automatic logic [11:0] bg_colour(input logic [2:0] en);
        return {(en[2] ? 4'h8 : 4'h0), (en[1] ? 4'h8 : 4'h0), (en[0] ? 4'h8 : 4'h0)};
    endfunction

    logic             act_s0, fld_s0, last_s0;
    logic [9:0]       vrel_s0;
    logic             vld_p1, fld_p1, last_p1;
    logic [4:0]       col_p1, tx_p1, ty_p1;
    logic [3:0]       row_p1;
    logic             cursor_ok, hit_s1;
    logic             vld_p2, fld_p2, hit_p2;
    logic             show;
    logic [11:0]      rgb_s2, rgb_p3;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    // Stage 1: coordinate decode and cell-store read
    always_comb begin
        vrel_s0 = v_coord - TOP_V;
        act_s0  = (h_coord < 11'd800) && (v_coord < 10'd600);
        // vrel >= 512 would alias row bits, so it counts as outside the field
        fld_s0  = act_s0 && (v_coord >= TOP_V) && !vrel_s0[9]
                  && ({1'b0, h_coord[9:5]} < COLS_L) && ({1'b0, vrel_s0[8:5]} < ROWS_L);
        last_s0 = (h_coord == 11'd799) && (v_coord == 10'd599);
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            fld_p1       <= 1'b0;
            last_p1      <= 1'b0;
            frame_pulse  <= 1'b0;
            cell_rd_en   <= 1'b0;
            cell_rd_addr <= '0;
        end else begin
            vld_p1       <= act_s0;
            fld_p1       <= fld_s0;
            last_p1      <= last_s0;
            frame_pulse  <= last_s0 && !last_p1;
            cell_rd_en   <= fld_s0;
            cell_rd_addr <= {vrel_s0[8:5], h_coord[9:5]};
        end
    end

    always_ff @(posedge pixel_clk) begin
        col_p1 <= h_coord[9:5];
        row_p1 <= vrel_s0[8:5];
        tx_p1  <= h_coord[4:0];
        ty_p1  <= vrel_s0[4:0];
    end

    // Stage 2: sprite selection and cursor hit
    always_comb begin
        cursor_ok = ({1'b0, player_x} < COLS_L) && ({1'b0, player_y} < ROWS_L);
        hit_s1    = cursor_ok && (col_p1 == player_x) && (row_p1 == player_y)
                    && (on_border(tx_p1) || on_border(ty_p1));
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            fld_p2     <= 1'b0;
            sprite_sel <= 4'd0;
            rom_addr   <= 10'd0;
        end else begin
            vld_p2     <= vld_p1;
            fld_p2     <= fld_p1;
            sprite_sel <= fld_p1 ? sprite_of(cell_state_i, cell_vis_i) : 4'd0;
            rom_addr   <= {ty_p1, tx_p1};
        end
    end

    always_ff @(posedge pixel_clk) begin
        hit_p2 <= hit_s1;
    end

    // Stage 3: colour mux and output register
    always_comb begin
        show   = !cursor_blink_en || !blink_phase;
        rgb_s2 = 12'h000;
        if (vld_p2) begin
            if (!fld_p2)             rgb_s2 = bg_colour(sw_bg);
            else if (hit_p2 && show) rgb_s2 = CURSOR_RGB;
            else                     rgb_s2 = rom_data_i;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            rgb_p3    <= 12'h000;
            pix_valid <= 1'b0;
        end else begin
            rgb_p3    <= rgb_s2;
            pix_valid <= vld_p2;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_pulse) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign red   = rgb_p3[3:0];
    assign green = rgb_p3[7:4];
    assign blue  = rgb_p3[11:8];

endmodule

// File: tb/tb_tile_render_ctrl.sv
// Bench for tile_render_ctrl: directed pins plus randomized coordinates checked every cycle
// against a cycle-indexed behavioural model of the pixel pipeline.
module tb_tile_render_ctrl;

    localparam int BF   = 2;
    localparam int MAXC = 12000;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic [2:0]  sw_bg;
    logic [4:0]  player_x;
    logic [3:0]  player_y;
    logic        cursor_blink_en;
    logic        cell_rd_en;
    logic [8:0]  cell_rd_addr;
    logic [3:0]  cell_state_i;
    logic [1:0]  cell_vis_i;
    logic [3:0]  sprite_sel;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data_i;
    logic [3:0]  red, green, blue;
    logic        pix_valid;
    logic        frame_pulse;

    tile_render_ctrl #(.BLINK_FRAMES(BF)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .h_coord(h_coord), .v_coord(v_coord),
        .sw_bg(sw_bg), .player_x(player_x), .player_y(player_y),
        .cursor_blink_en(cursor_blink_en), .cell_rd_en(cell_rd_en), .cell_rd_addr(cell_rd_addr),
        .cell_state_i(cell_state_i), .cell_vis_i(cell_vis_i), .sprite_sel(sprite_sel),
        .rom_addr(rom_addr), .rom_data_i(rom_data_i), .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .frame_pulse(frame_pulse)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit rst;
        int h;
        int v;
        int bg;
        int px;
        int py;
        bit ben;
    } rec_t;

    rec_t       hist [MAXC];
    int         fcnt [MAXC];
    bit         ev   [MAXC];
    logic [3:0] cst  [512];
    logic [1:0] cvis [512];
    logic [5:0] junk;
    int         edge_n = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         ev_cnt = 0;
    bit         prev_ok = 0;

    function automatic logic [11:0] rom_word(input logic [3:0] s, input logic [9:0] a);
        return (12'(s) * 12'd419) ^ {2'b00, a} ^ 12'h5C3;
    endfunction

    assign rom_data_i   = rom_word(sprite_sel, rom_addr);
    assign cell_state_i = cell_rd_en ? cst[cell_rd_addr]  : junk[3:0];
    assign cell_vis_i   = cell_rd_en ? cvis[cell_rd_addr] : junk[5:4];

    function automatic int spr_model(input int st, input int vis);
        if (vis == 1) return 1;
        if (vis != 2) return 0;
        if (st == 0)  return 12;
        if (st <= 8)  return st + 1;
        if (st == 9)  return 10;
        if (st == 10) return 11;
        return 0;
    endfunction

    function automatic bit fld_of(input int h, input int v);
        return (h < 800) && (v < 600) && (v >= 88);
    endfunction

    function automatic int addr_of(input int h, input int v);
        return ((v - 88) / 32) * 32 + h / 32;
    endfunction

    function automatic logic [11:0] bgc(input int bg);
        logic [11:0] c;
        c = 12'h000;
        if ((bg & 4) != 0) c[11:8] = 4'h8;
        if ((bg & 2) != 0) c[7:4]  = 4'h8;
        if ((bg & 1) != 0) c[3:0]  = 4'h8;
        return c;
    endfunction

    // colour of the pixel whose coordinates were applied in input cycle j
    function automatic logic [11:0] pixel_exp(input int j);
        int h, v, tx, ty, a;
        bit hit, show;
        h = hist[j].h;
        v = hist[j].v;
        if (!(h < 800 && v < 600)) return 12'h000;
        if (v < 88) return bgc(hist[j+2].bg);
        tx   = h % 32;
        ty   = (v - 88) % 32;
        a    = addr_of(h, v);
        hit  = (h / 32 == hist[j+1].px) && ((v - 88) / 32 == hist[j+1].py)
               && hist[j+1].px < 25 && hist[j+1].py < 16
               && (tx < 2 || tx > 29 || ty < 2 || ty > 29);
        show = !hist[j+2].ben || ((fcnt[j] / BF) % 2 == 0);
        if (hit && show) return 12'hF00;
        return rom_word(4'(spr_model(int'(cst[a]), int'(cvis[a]))), 10'(ty * 32 + tx));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic check_edge(input int n);
        logic [11:0] rgb;
        int a2, j;
        rgb = {blue, green, red};
        if (hist[n-1].rst) begin
            chk("rst_rd_en",   32'(cell_rd_en),   32'd0);
            chk("rst_rd_addr", 32'(cell_rd_addr), 32'd0);
            chk("rst_sprite",  32'(sprite_sel),   32'd0);
            chk("rst_rom_addr",32'(rom_addr),     32'd0);
            chk("rst_rgb",     32'(rgb),          32'd0);
            chk("rst_pix_valid",32'(pix_valid),   32'd0);
            chk("rst_frame_pulse",32'(frame_pulse),32'd0);
            return;
        end
        chk("rd_en", 32'(cell_rd_en), 32'(fld_of(hist[n-1].h, hist[n-1].v)));
        if (fld_of(hist[n-1].h, hist[n-1].v))
            chk("rd_addr", 32'(cell_rd_addr), 32'(addr_of(hist[n-1].h, hist[n-1].v)));
        chk("frame_pulse", 32'(frame_pulse), 32'(ev[n-1]));
        if (!hist[n-2].rst && fld_of(hist[n-2].h, hist[n-2].v)) begin
            a2 = addr_of(hist[n-2].h, hist[n-2].v);
            chk("sprite_sel", 32'(sprite_sel), 32'(spr_model(int'(cst[a2]), int'(cvis[a2]))));
            chk("rom_addr", 32'(rom_addr),
                32'(((hist[n-2].v - 88) % 32) * 32 + hist[n-2].h % 32));
        end
        if (hist[n-2].rst || hist[n-3].rst) begin
            chk("flush_pix_valid", 32'(pix_valid), 32'd0);
            chk("flush_rgb", 32'(rgb), 32'd0);
        end else begin
            j = n - 3;
            chk("pix_valid", 32'(pix_valid), 32'(hist[j].h < 800 && hist[j].v < 600));
            chk("rgb", 32'(rgb), 32'(pixel_exp(j)));
        end
    endtask

    always @(posedge pixel_clk) begin
        #1;
        edge_n++;
        if (edge_n >= 4) check_edge(edge_n);
    end

    task automatic drive(input bit rst, input int h, input int v);
        int t;
        bit lst;
        rst_n   = !rst;
        h_coord = 11'(h);
        v_coord = 10'(v);
        junk    = 6'($urandom);
        t = edge_n;
        hist[t].rst = rst;
        hist[t].h   = h;
        hist[t].v   = v;
        hist[t].bg  = int'(sw_bg);
        hist[t].px  = int'(player_x);
        hist[t].py  = int'(player_y);
        hist[t].ben = cursor_blink_en;
        if (t == 0 || hist[t-1].rst) begin
            ev_cnt  = 0;
            prev_ok = 0;
        end
        lst   = (h == 799) && (v == 599);
        ev[t] = lst && !(prev_ok && hist[t-1].h == 799 && hist[t-1].v == 599);
        if (ev[t]) ev_cnt++;
        fcnt[t] = ev_cnt;
        prev_ok = 1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 810, 0);
    endtask

    task automatic rand_pixel();
        int sel, off, h, v;
        sel = int'($urandom_range(0, 99));
        if (sel < 55) begin
            h = int'($urandom_range(0, 799));
            v = int'($urandom_range(88, 599));
        end else if (sel < 80) begin
            off = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(30, 31));
            if ($urandom_range(0, 1) == 0) begin
                h = int'(player_x) * 32 + off;
                v = 88 + int'(player_y) * 32 + int'($urandom_range(0, 31));
            end else begin
                h = int'(player_x) * 32 + int'($urandom_range(0, 31));
                v = 88 + int'(player_y) * 32 + off;
            end
        end else if (sel < 92) begin
            h = int'($urandom_range(0, 799));
            v = int'($urandom_range(0, 87));
        end else begin
            h = int'($urandom_range(0, 2047));
            v = int'($urandom_range(0, 1023));
        end
        drive(($urandom_range(0, 399) == 0), h, v);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            cst[i]  = 4'($urandom);
            cvis[i] = 2'($urandom);
        end
        cst[0]      = 4'd3;
        cvis[0]     = 2'd2;
        cvis[9'h021] = 2'd1;
        cvis[9'h062] = 2'd0;
        sw_bg           = 3'b101;
        player_x        = 5'd2;
        player_y        = 4'd3;
        cursor_blink_en = 1'b0;

        for (int i = 0; i < 4; i++) drive(1, 810, 0);

        // revealed count-3 cell at the field origin
        drive(0, 0, 88);
        chk("t1_rd_en", 32'(cell_rd_en), 32'd1);
        chk("t1_rd_addr", 32'(cell_rd_addr), 32'h000);
        idle(1);
        chk("t1_sprite", 32'(sprite_sel), 32'd4);
        chk("t1_rom_addr", 32'(rom_addr), 32'd0);
        idle(1);
        chk("t1_rgb", 32'({blue, green, red}), 32'(rom_word(4'd4, 10'd0)));
        chk("t1_pix_valid", 32'(pix_valid), 32'd1);

        // flagged cell at col 1, row 1
        drive(0, 37, 130);
        chk("t2_rd_addr", 32'(cell_rd_addr), 32'h021);
        idle(1);
        chk("t2_sprite", 32'(sprite_sel), 32'd1);
        chk("t2_rom_addr", 32'(rom_addr), 32'h145);
        idle(1);

        // above the field, then beyond the visible width
        drive(0, 100, 50);
        chk("t3_rd_en", 32'(cell_rd_en), 32'd0);
        idle(2);
        chk("t3_bg_rgb", 32'({blue, green, red}), 32'h808);
        chk("t3_bg_valid", 32'(pix_valid), 32'd1);
        drive(0, 810, 50);
        idle(2);
        chk("t3_off_rgb", 32'({blue, green, red}), 32'h000);
        chk("t3_off_valid", 32'(pix_valid), 32'd0);

        // steady cursor on cell (2,3)
        drive(0, 64, 184);
        idle(2);
        chk("t4_cursor_tx0", 32'({blue, green, red}), 32'hF00);
        drive(0, 74, 184);
        idle(2);
        chk("t4_cursor_ty0", 32'({blue, green, red}), 32'hF00);
        drive(0, 74, 194);
        idle(2);
        chk("t4_interior", 32'({blue, green, red}), 32'(rom_word(4'd0, 10'h14A)));

        // blinking cursor, two frames per half-period
        drive(1, 810, 0);
        drive(1, 810, 0);
        cursor_blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            drive(0, 64, 184);
            idle(2);
            chk("t5_blink", 32'({blue, green, red}),
                ((f / 2) % 2 == 0) ? 32'hF00 : 32'(rom_word(4'd0, 10'd0)));
            drive(0, 799, 599);
            chk("t5_pulse", 32'(frame_pulse), 32'd1);
            drive(0, 799, 599);
            chk("t5_pulse_once", 32'(frame_pulse), 32'd0);
            idle(1);
        end

        // one-cycle reset mid-line
        cursor_blink_en = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 88);
        drive(1, 10, 100);
        chk("t6_rd_en", 32'(cell_rd_en), 32'd0);
        chk("t6_sprite", 32'(sprite_sel), 32'd0);
        chk("t6_rgb", 32'({blue, green, red}), 32'd0);
        chk("t6_pix_valid", 32'(pix_valid), 32'd0);
        drive(0, 0, 88);
        drive(0, 0, 88);
        chk("t6_valid_early", 32'(pix_valid), 32'd0);
        drive(0, 0, 88);
        chk("t6_valid_back", 32'(pix_valid), 32'd1);
        cursor_blink_en = 1'b1;
        drive(0, 64, 184);
        idle(2);
        chk("t6_cnt_restart", 32'({blue, green, red}), 32'hF00);

        // randomized frames
        for (int f = 0; f < 150; f++) begin
            int nc;
            nc = int'($urandom_range(20, 50));
            for (int c = 0; c < nc; c++) begin
                if ($urandom_range(0, 29) == 0) player_x = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 29) == 0) player_y = 4'($urandom);
                if ($urandom_range(0, 29) == 0) sw_bg = 3'($urandom);
                if ($urandom_range(0, 39) == 0) cursor_blink_en = 1'($urandom);
                rand_pixel();
            end
            drive(0, 799, 599);
            if ($urandom_range(0, 2) == 0) drive(0, 799, 599);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
